// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS sequencing controller.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables, mux selects and ALU operation per state.
// Optional feature macro: MC_MEM_WAIT_EN (memory accesses stall on mem_ready).
// ALU and extension codes come from the ALUOp_* / EXT_* macros; the values
// below are used only when those macros have not already been defined.

`ifndef ALUOp_NOP
`define ALUOp_NOP  5'd0
`endif
`ifndef ALUOp_LUI
`define ALUOp_LUI  5'd1
`endif
`ifndef ALUOp_ADD
`define ALUOp_ADD  5'd2
`endif
`ifndef ALUOp_ADDU
`define ALUOp_ADDU 5'd3
`endif
`ifndef ALUOp_SUB
`define ALUOp_SUB  5'd4
`endif
`ifndef ALUOp_SUBU
`define ALUOp_SUBU 5'd5
`endif
`ifndef ALUOp_AND
`define ALUOp_AND  5'd6
`endif
`ifndef ALUOp_OR
`define ALUOp_OR   5'd7
`endif
`ifndef ALUOp_NOR
`define ALUOp_NOR  5'd8
`endif
`ifndef ALUOp_XOR
`define ALUOp_XOR  5'd9
`endif
`ifndef ALUOp_SLT
`define ALUOp_SLT  5'd10
`endif
`ifndef ALUOp_SLTU
`define ALUOp_SLTU 5'd11
`endif
`ifndef ALUOp_SLL
`define ALUOp_SLL  5'd12
`endif
`ifndef ALUOp_SRL
`define ALUOp_SRL  5'd13
`endif
`ifndef EXT_ZERO
`define EXT_ZERO   1'b0
`endif
`ifndef EXT_SIGNED
`define EXT_SIGNED 1'b1
`endif

module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       MemR,
  output logic       MemW,
  output logic       RegW,
  output logic       RegDst,
  output logic       Mem2R,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       ExtOp,
  output logic [4:0] Aluctrl,
  output logic [1:0] PCSrc,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXE_R   = 4'd2,
    S_EXE_I   = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_MEM  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;
  logic   mem_done;

`ifdef MC_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  // Every access completes in one cycle; mem_ready is deliberately unused.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif

  assign state = state_q;

  // State register; reset returns to FETCH and aborts any instruction.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state datapath controls; write strobes gated by reset.
  always_comb begin
    state_d = S_FETCH;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    MemR    = 1'b0;
    MemW    = 1'b0;
    RegW    = 1'b0;
    RegDst  = 1'b0;
    Mem2R   = 1'b0;
    AluSrcA = 1'b0;
    AluSrcB = 2'b00;
    ExtOp   = `EXT_ZERO;
    Aluctrl = `ALUOp_NOP;
    PCSrc   = 2'b00;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemR    = 1'b1;
        IRWr    = mem_done;
        PCWr    = mem_done;
        AluSrcB = 2'b01;
        Aluctrl = `ALUOp_ADDU;
        state_d = mem_done ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        AluSrcB = 2'b11;
        ExtOp   = `EXT_SIGNED;
        Aluctrl = `ALUOp_ADDU;
        case (OpCode)
          OP_RTYPE:               state_d = S_EXE_R;
          OP_LW, OP_SW:           state_d = S_MEM_ADR;
          OP_ORI, OP_ADDI, OP_LUI: state_d = S_EXE_I;
          OP_BEQ, OP_BNE:         state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXE_R: begin
        AluSrcA = 1'b1;
        state_d = S_WB_ALU;
        case (funct)
          6'b100000: Aluctrl = `ALUOp_ADD;
          6'b100001: Aluctrl = `ALUOp_ADDU;
          6'b100010: Aluctrl = `ALUOp_SUB;
          6'b100011: Aluctrl = `ALUOp_SUBU;
          6'b100100: Aluctrl = `ALUOp_AND;
          6'b100111: Aluctrl = `ALUOp_NOR;
          6'b100101: Aluctrl = `ALUOp_OR;
          6'b100110: Aluctrl = `ALUOp_XOR;
          6'b101010: Aluctrl = `ALUOp_SLT;
          6'b101011: Aluctrl = `ALUOp_SLTU;
          6'b000000: Aluctrl = `ALUOp_SLL;
          6'b000010: Aluctrl = `ALUOp_SRL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXE_I: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = S_WB_ALU;
        case (OpCode)
          OP_ORI: begin
            Aluctrl = `ALUOp_OR;
            ExtOp   = `EXT_ZERO;
          end
          OP_ADDI: begin
            Aluctrl = `ALUOp_ADD;
            ExtOp   = `EXT_SIGNED;
          end
          OP_LUI: begin
            Aluctrl = `ALUOp_LUI;
            ExtOp   = `EXT_SIGNED;
          end
          default: ;
        endcase
      end
      S_MEM_ADR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        ExtOp   = `EXT_SIGNED;
        Aluctrl = `ALUOp_ADDU;
        state_d = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemR    = 1'b1;
        state_d = mem_done ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        MemW    = 1'b1;
        state_d = mem_done ? S_FETCH : S_MEM_WR;
      end
      S_WB_MEM: begin
        RegW  = 1'b1;
        Mem2R = 1'b1;
      end
      S_WB_ALU: begin
        RegW   = 1'b1;
        RegDst = (OpCode == OP_RTYPE);
      end
      S_BRANCH: begin
        AluSrcA = 1'b1;
        Aluctrl = `ALUOp_SUBU;
        PCSrc   = 2'b01;
        PCWr    = (OpCode == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSrc = 2'b10;
        PCWr  = 1'b1;
      end
      default: ;
    endcase
    // No architectural side effects while reset is held.
    if (rst) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      MemR    = 1'b0;
      MemW    = 1'b0;
      RegW    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule
